// File: rtl/int_controller.sv
// -----------------------------------------------------------------------------
// int_controller
//   Prioritised, non-nesting interrupt controller. Rising edges on the irq
//   lines latch pending bits. Unmasked pending lines are arbitrated, and the
//   lowest index wins. The winner is presented to the processor until it
//   acknowledges, and no new grant is made until the handler returns (rti).
//
// Parameters
//   NUM_IRQ    number of request lines (index 0 = highest priority)
//   VEC_W      int_vector width, 2**VEC_W >= NUM_IRQ
//   MASK_RESET reset value of the mask register (1 = masked)
//
// Ports
//   clk        clock, rising edge active
//   reset      asynchronous, active-high reset
//   irq        request lines; a rising edge raises a request
//   int_ack    one-cycle pulse: processor entered the handler
//   rti        one-cycle pulse: processor returned from the handler
//   mask_we    mask register write enable
//   mask_in    new mask value
//   interrupt  registered interrupt request to the processor
//   int_vector index of the granted line (valid with interrupt or in_service)
//   in_service registered, high while the handler runs
//   pending    registered pending bits
//   mask       current mask register
// -----------------------------------------------------------------------------
module int_controller #(
  parameter int                 NUM_IRQ    = 4,
  parameter int                 VEC_W      = 2,
  parameter logic [NUM_IRQ-1:0] MASK_RESET = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               int_ack,
  input  logic               rti,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_in,
  output logic               interrupt,
  output logic [VEC_W-1:0]   int_vector,
  output logic               in_service,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] mask
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_t;

  state_t             state;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] grant_clr;
  logic [VEC_W-1:0]   winner;

  // irq_q is cleared by reset, so a line already high when reset releases
  // is seen as a fresh rising edge on the first clock.
  assign rise     = irq & ~irq_q;
  assign eligible = pending & ~mask;

  // Fixed-priority encoder: scanning from the top down lets the lowest set
  // index overwrite any higher one.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = VEC_W'(i);
    end
  end

  // Pending bit of the granted line is cleared on the acknowledge edge only.
  always_comb begin
    grant_clr = '0;
    if (state == REQ && int_ack) begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (int_vector == VEC_W'(i)) grant_clr[i] = 1'b1;
      end
    end
  end

  // Edge detect, pending latch and mask register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: state is reset through the async branch only and updated with
      // non-blocking assignments, so every register samples pre-edge values.
      irq_q   <= '0;
      pending <= '0;
      mask    <= MASK_RESET;
    end else begin
      irq_q   <= irq;
      // A new rise wins over a same-edge grant clear, so a request landing
      // exactly on the acknowledge edge is not lost.
      pending <= (pending & ~grant_clr) | rise;
      if (mask_we) mask <= mask_in;
    end
  end

  // Grant FSM with registered outputs. int_vector loads only on the
  // IDLE->REQ edge, so it stays frozen through REQ and SERVICE: no
  // preemption, and a mask write cannot retract a request already raised.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      interrupt  <= 1'b0;
      in_service <= 1'b0;
      int_vector <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|eligible) begin
            state      <= REQ;
            interrupt  <= 1'b1;
            int_vector <= winner;
          end
        end
        REQ: begin
          if (int_ack) begin
            state      <= SERVICE;
            interrupt  <= 1'b0;
            in_service <= 1'b1;
          end
        end
        SERVICE: begin
          if (rti) begin
            state      <= IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          interrupt  <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_controller.sv
// -----------------------------------------------------------------------------
// tb_int_controller
//   Self-checking bench for int_controller. A behavioural model tracks the
//   controller phase, the pending set and the mask from the behaviour rules.
//   Directed scenarios and a randomised run are compared against the model
//   every cycle. Directed scenarios also check fixed expected values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_int_controller;

  localparam int             N  = 4;
  localparam int             VW = 2;
  localparam logic [N-1:0]   MR = 4'b0000;

  typedef struct packed {
    logic [N-1:0] irq;
    logic         ack;
    logic         rti;
    logic         we;
    logic [N-1:0] min;
  } stim_t;

  logic          clk;
  logic          reset;
  logic [N-1:0]  irq;
  logic          int_ack;
  logic          rti;
  logic          mask_we;
  logic [N-1:0]  mask_in;
  logic          interrupt;
  logic [VW-1:0] int_vector;
  logic          in_service;
  logic [N-1:0]  pending;
  logic [N-1:0]  mask;

  int n_checks = 0;
  int n_fail   = 0;

  int_controller #(
    .NUM_IRQ   (N),
    .VEC_W     (VW),
    .MASK_RESET(MR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .irq       (irq),
    .int_ack   (int_ack),
    .rti       (rti),
    .mask_we   (mask_we),
    .mask_in   (mask_in),
    .interrupt (interrupt),
    .int_vector(int_vector),
    .in_service(in_service),
    .pending   (pending),
    .mask      (mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // m_phase: 0 = waiting for work, 1 = request raised, 2 = handler running.
  int m_phase;
  int m_vec;
  bit m_pend [N];
  bit m_mask [N];
  bit m_prev [N];

  function automatic void model_reset();
    m_phase = 0;
    m_vec   = 0;
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 1'b0;
      m_mask[i] = MR[i];
      m_prev[i] = 1'b0;
    end
  endfunction

  function automatic void model_step(stim_t s);
    bit nxt [N];
    int win;
    win = -1;
    for (int i = N - 1; i >= 0; i--) begin
      if (m_pend[i] && !m_mask[i]) win = i;
    end
    nxt = m_pend;
    case (m_phase)
      0: if (win >= 0) begin m_phase = 1; m_vec = win; end
      1: if (s.ack) begin m_phase = 2; nxt[m_vec] = 1'b0; end
      2: if (s.rti) m_phase = 0;
      default: ;
    endcase
    for (int i = 0; i < N; i++) begin
      if (s.irq[i] && !m_prev[i]) nxt[i] = 1'b1;
      if (s.we) m_mask[i] = s.min[i];
      m_prev[i] = s.irq[i];
    end
    m_pend = nxt;
  endfunction

  // {interrupt, in_service, vector (only while valid), pending, mask}
  function automatic logic [11:0] exp_vec();
    logic [N-1:0]  p;
    logic [N-1:0]  k;
    logic [VW-1:0] v;
    for (int i = 0; i < N; i++) begin
      p[i] = m_pend[i];
      k[i] = m_mask[i];
    end
    v = (m_phase != 0) ? VW'(m_vec) : 2'b00;
    return {m_phase == 1, m_phase == 2, v, p, k};
  endfunction

  function automatic logic [11:0] obs_vec();
    logic [VW-1:0] v;
    v = (m_phase != 0) ? int_vector : 2'b00;
    return {interrupt, in_service, v, pending, mask};
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic stim_t st(logic [N-1:0] i, logic a, logic r, logic w, logic [N-1:0] m);
    return {i, a, r, w, m};
  endfunction
  function automatic stim_t s_irq(logic [N-1:0] i); return st(i, 1'b0, 1'b0, 1'b0, 4'b0000); endfunction
  function automatic stim_t s_ack();                return st(4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000); endfunction
  function automatic stim_t s_rti();                return st(4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000); endfunction
  function automatic stim_t s_mw(logic [N-1:0] m);  return st(4'b0000, 1'b0, 1'b0, 1'b1, m); endfunction

  // Drive one cycle of inputs, advance the model, and return 1 ns after the edge.
  task automatic run_cycle(stim_t s);
    irq     = s.irq;
    int_ack = s.ack;
    rti     = s.rti;
    mask_we = s.we;
    mask_in = s.min;
    model_step(s);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(logic [N-1:0] irq_v);
    reset   = 1'b1;
    irq     = irq_v;
    int_ack = 1'b0;
    rti     = 1'b0;
    mask_we = 1'b0;
    mask_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [11:0] got;
    reset = 1'b1; irq = 4'b0100; int_ack = 1'b0; rti = 1'b0; mask_we = 1'b0; mask_in = '0;
    model_reset();
    @(posedge clk); #1;
    got = {interrupt, in_service, int_vector, pending, mask};
    n_checks++;
    if (got !== {1'b0, 1'b0, 2'b00, 4'b0000, MR}) begin
      n_fail++; $display("FAIL reset_values: got %b, want %b", got, {4'b0000, 4'b0000, MR});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    // Line held high across reset release counts as a rise on the first edge.
    run_cycle(s_irq(4'b0100));
    n_checks++;
    if ({interrupt, pending} !== 5'b0_0100) begin
      n_fail++; $display("FAIL reset_release_rise: got %b, want %b", {interrupt, pending}, 5'b0_0100);
    end
    run_cycle(s_irq(4'b0100));
    n_checks++;
    if (obs_vec() !== exp_vec() || {interrupt, int_vector} !== 3'b1_10) begin
      n_fail++; $display("FAIL reset_release_grant: got %b, want %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_single();
    stim_t tab [9];
    apply_reset(4'b0000);
    tab = '{s_irq(4'b0000), s_irq(4'b0100), s_irq(4'b0000), s_irq(4'b0000), s_irq(4'b0000),
            s_ack(), s_irq(4'b0000), s_rti(), s_irq(4'b0000)};
    for (int i = 0; i < 9; i++) begin
      run_cycle(tab[i]);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL single[%0d]: got %b, want %b", i, obs_vec(), exp_vec());
      end
      if (i == 2) begin
        n_checks++;
        if ({interrupt, int_vector} !== 3'b1_10) begin
          n_fail++; $display("FAIL single_grant: got %b, want %b", {interrupt, int_vector}, 3'b1_10);
        end
      end
      if (i == 5) begin
        n_checks++;
        if ({interrupt, in_service, pending} !== 6'b0_1_0000) begin
          n_fail++; $display("FAIL single_ack: got %b, want %b", {interrupt, in_service, pending}, 6'b010000);
        end
      end
      if (i == 7) begin
        n_checks++;
        if ({interrupt, in_service} !== 2'b00) begin
          n_fail++; $display("FAIL single_rti: got %b, want %b", {interrupt, in_service}, 2'b00);
        end
      end
    end
  endtask

  task automatic test_priority();
    stim_t tab [7];
    apply_reset(4'b0000);
    tab = '{s_irq(4'b1010), s_irq(4'b0000), s_ack(), s_rti(), s_irq(4'b0000), s_ack(), s_rti()};
    for (int i = 0; i < 7; i++) begin
      run_cycle(tab[i]);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL priority[%0d]: got %b, want %b", i, obs_vec(), exp_vec());
      end
      if (i == 1 || i == 4) begin
        n_checks++;
        if ({interrupt, int_vector} !== {1'b1, (i == 1) ? 2'd1 : 2'd3}) begin
          n_fail++; $display("FAIL priority_vec[%0d]: got %b, want vector %0d", i, {interrupt, int_vector}, (i == 1) ? 1 : 3);
        end
      end
    end
  endtask

  task automatic test_no_preempt();
    stim_t tab [8];
    apply_reset(4'b0000);
    tab = '{s_irq(4'b0100), s_irq(4'b0000), s_irq(4'b0001), s_irq(4'b0000),
            s_ack(), s_irq(4'b0000), s_rti(), s_irq(4'b0000)};
    for (int i = 0; i < 8; i++) begin
      run_cycle(tab[i]);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL no_preempt[%0d]: got %b, want %b", i, obs_vec(), exp_vec());
      end
      if (i == 3 || i == 7) begin
        n_checks++;
        if ({interrupt, int_vector} !== {1'b1, (i == 3) ? 2'd2 : 2'd0}) begin
          n_fail++; $display("FAIL no_preempt_vec[%0d]: got %b, want vector %0d", i, {interrupt, int_vector}, (i == 3) ? 2 : 0);
        end
      end
    end
  endtask

  task automatic test_mask();
    stim_t tab [10];
    apply_reset(4'b0000);
    tab = '{s_mw(4'b0001), s_irq(4'b0001), s_irq(4'b0000), s_irq(4'b0000), s_mw(4'b0000),
            s_irq(4'b0000), s_mw(4'b0001), s_irq(4'b0000), s_ack(), s_rti()};
    for (int i = 0; i < 10; i++) begin
      run_cycle(tab[i]);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL mask[%0d]: got %b, want %b", i, obs_vec(), exp_vec());
      end
      if (i == 3) begin
        n_checks++;
        if ({interrupt, pending} !== 5'b0_0001) begin
          n_fail++; $display("FAIL mask_hold: got %b, want %b", {interrupt, pending}, 5'b0_0001);
        end
      end
      if (i == 5 || i == 7) begin
        n_checks++;
        if ({interrupt, int_vector} !== 3'b1_00) begin
          n_fail++; $display("FAIL mask_grant[%0d]: got %b, want %b", i, {interrupt, int_vector}, 3'b1_00);
        end
      end
    end
  endtask

  task automatic test_boundaries();
    stim_t tab [12];
    apply_reset(4'b0000);
    tab = '{s_ack(), s_rti(), s_irq(4'b0100), s_irq(4'b0000), s_rti(), s_irq(4'b0000),
            st(4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000), s_ack(), s_irq(4'b0100), s_rti(),
            s_irq(4'b0000), s_ack()};
    for (int i = 0; i < 12; i++) begin
      run_cycle(tab[i]);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL bound[%0d]: got %b, want %b", i, obs_vec(), exp_vec());
      end
      if (i == 1) begin
        n_checks++;
        if ({interrupt, in_service, pending} !== 6'b0) begin
          n_fail++; $display("FAIL stray_idle: got %b, want %b", {interrupt, in_service, pending}, 6'b0);
        end
      end
      if (i == 4) begin
        n_checks++;
        if ({interrupt, in_service, int_vector} !== 4'b1_0_10) begin
          n_fail++; $display("FAIL stray_rti_req: got %b, want %b", {interrupt, in_service, int_vector}, 4'b1010);
        end
      end
      if (i == 6) begin
        n_checks++;
        if ({interrupt, in_service, pending} !== 6'b0_1_0100) begin
          n_fail++; $display("FAIL set_wins_clear: got %b, want %b", {interrupt, in_service, pending}, 6'b010100);
        end
      end
      if (i == 11) begin
        n_checks++;
        if ({in_service, pending} !== 5'b1_0000) begin
          n_fail++; $display("FAIL single_bit_pending: got %b, want %b", {in_service, pending}, 5'b10000);
        end
      end
    end
  endtask

  task automatic test_reset_async();
    stim_t tab [6];
    logic [11:0] got;
    apply_reset(4'b0000);
    tab = '{s_mw(4'b1000), s_irq(4'b0100), s_irq(4'b0000), s_ack(), s_irq(4'b0110), s_irq(4'b0000)};
    for (int i = 0; i < 6; i++) begin
      run_cycle(tab[i]);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL async_setup[%0d]: got %b, want %b", i, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if ({in_service, pending, mask} !== 9'b1_0110_1000) begin
      n_fail++; $display("FAIL async_pre: got %b, want %b", {in_service, pending, mask}, 9'b101101000);
    end
    // Assert reset mid-cycle; outputs must clear before the next clock edge.
    #2 reset = 1'b1;
    #1;
    got = {interrupt, in_service, int_vector, pending, mask};
    n_checks++;
    if (got !== {1'b0, 1'b0, 2'b00, 4'b0000, MR}) begin
      n_fail++; $display("FAIL async_reset: got %b, want %b", got, {8'b0, MR});
    end
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    run_cycle(s_irq(4'b0000));
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL async_after: got %b, want %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    logic [N-1:0] cur;
    logic [11:0]  got;
    stim_t        s;
    apply_reset(4'b0000);
    cur = '0;
    for (int c = 0; c < 800; c++) begin
      cur = cur ^ N'($urandom & $urandom);
      s = st(cur, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 11) == 0, N'($urandom));
      run_cycle(s);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random[%0d]: got %b, want %b", c, obs_vec(), exp_vec());
      end
      if ($urandom_range(0, 149) == 0) begin
        #2 reset = 1'b1;
        #1;
        got = {interrupt, in_service, int_vector, pending, mask};
        n_checks++;
        if (got !== {1'b0, 1'b0, 2'b00, 4'b0000, MR}) begin
          n_fail++; $display("FAIL random_reset[%0d]: got %b, want %b", c, got, {8'b0, MR});
        end
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_no_preempt();
    test_mask();
    test_boundaries();
    test_reset_async();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/int_controller.md
INT_CONTROLLER -- requirements
Module: int_controller

Interface
REQ-001 Parameter NUM_IRQ, default 4: number of external interrupt request lines, with index 0 the highest priority.
REQ-002 Parameter VEC_W, default 2: int_vector width; shall satisfy 2^VEC_W >= NUM_IRQ.
REQ-003 Parameter MASK_RESET, default 0: reset value of the mask register, where 1 means masked.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high; forces every register to its reset value immediately.
REQ-006 irq  input  NUM_IRQ  request lines, synchronous to clk; the rising edge of each line is the request.
REQ-007 int_ack  input  1  one-cycle pulse from the processor meaning it has accepted the interrupt (handler entered).
REQ-008 rti  input  1  one-cycle pulse from the processor meaning return-from-interrupt has completed.
REQ-009 mask_we  input  1  mask register write enable.
REQ-010 mask_in  input  NUM_IRQ  new mask value.
REQ-011 interrupt  output  1  registered request to the processor interrupt input.
REQ-012 int_vector  output  VEC_W  index of the granted line; valid while interrupt=1 or in_service=1.
REQ-013 in_service  output  1  registered; high while the handler runs.
REQ-014 pending  output  NUM_IRQ  registered pending bits.
REQ-015 mask  output  NUM_IRQ  current mask register.

Function
REQ-016 Edge detect: irq_q shall register irq every cycle; rise[i] = irq[i] & ~irq_q[i].
REQ-017 A rise[i] at edge k shall set pending[i] at edge k, in any FSM state.
REQ-018 If set (rise) and clear (grant) hit the same bit at the same edge, the bit shall stay set.
REQ-019 Masked lines shall still latch pending but shall not be eligible for arbitration.
REQ-020 eligible = pending & ~mask; the winner is the lowest index set in eligible.
REQ-021 The FSM shall have three states: IDLE, REQ and SERVICE.
REQ-022 IDLE -> REQ on a clock edge where eligible != 0; int_vector shall load the winner on that same edge.
REQ-023 REQ -> SERVICE on an edge with int_ack=1; pending[int_vector] shall clear on that edge.
REQ-024 SERVICE -> IDLE on an edge with rti=1.
REQ-025 interrupt shall be 1 exactly while state=REQ.
REQ-026 in_service shall be 1 exactly while state=SERVICE.
REQ-027 Latency: with irq[i] first sampled high at edge k and the controller idle, interrupt shall be high after edge k+1 (2 cycles).
REQ-028 In REQ, int_vector shall be frozen; a later higher-priority request shall not preempt it.
REQ-029 A request in REQ shall not be retracted by a mask write; mask applies only at the next IDLE arbitration.
REQ-030 No nesting: requests arriving in SERVICE shall only accumulate in pending.
REQ-031 After rti, arbitration shall occur in IDLE on the following edge, so interrupt re-asserts 2 cycles after rti if eligible != 0.
REQ-032 int_ack outside REQ shall be ignored.
REQ-033 rti outside SERVICE shall be ignored.
REQ-034 interrupt shall stay high in REQ indefinitely until int_ack, regardless of processor stall.
REQ-035 mask_we=1 shall load mask_in on that edge in any state.
REQ-036 A repeated rise on an already-pending line shall be absorbed; pending is a single bit, not a count.

Reset
REQ-037 While reset=1: state=IDLE, interrupt=0, in_service=0, int_vector=0, pending=0, irq_q=0, mask=MASK_RESET.
REQ-038 Reset mid-REQ or mid-SERVICE shall drop the request and all pending bits immediately, without waiting for a clock edge.
REQ-039 An irq line already high when reset deasserts shall count as a rising edge on the first clock edge.

Verification
REQ-040 Single request: irq=4'b0100 pulse at edge 10 -> interrupt=1 and int_vector=2 from edge 11; int_ack at edge 14 -> interrupt=0, in_service=1, pending=0; rti at edge 16 -> in_service=0.
REQ-041 Priority: irq=4'b1010 at one edge -> grant vector 1; after int_ack and rti -> grant vector 3 two cycles after rti.
REQ-042 No preemption: irq[2] granted, irq[0] rises while in REQ -> int_vector stays 2; irq[0] granted only after rti.
REQ-043 Masking: mask=4'b0001, irq[0] rises -> pending=4'b0001, interrupt stays 0; mask write 4'b0000 -> interrupt=1 with vector 0 two edges after the write.
REQ-044 Boundaries: stray int_ack in IDLE and stray rti in REQ -> no state change; rise on the granted bit coincident with int_ack -> that pending bit stays 1.
REQ-045 Async reset mid-SERVICE with pending=4'b0110 -> all outputs at reset values before the next clock edge; mask=MASK_RESET.
